// File: rtl/hub75_bcm_scanner_if.sv
// Frame-memory read port plus the buffer-swap handshake between the scanner and the image source.
interface hub75_bcm_scanner_if #(
  parameter int unsigned AW   = 5,
  parameter int unsigned CW   = 6,
  parameter int unsigned BITS = 4
);
  logic [AW+CW:0]    rd_addr;
  logic [6*BITS-1:0] rd_data;
  logic              swap_req;
  logic              swap_ack;
  logic              buf_sel;

  modport master (output rd_addr, swap_ack, buf_sel, input rd_data, swap_req);
  modport slave  (input rd_addr, swap_ack, buf_sel, output rd_data, swap_req);
endinterface

// File: rtl/hub75_bcm_scanner.sv
// HUB75 scan engine: shifts one BCM plane of a row pair, latches it, then shows it for BASE_T<<plane
// cycles; buffers flip only at the frame wrap so an image source can update tear-free.
module hub75_bcm_scanner #(
  parameter int unsigned COLS      = 64,
  parameter int unsigned ROWS_HALF = 32,
  parameter int unsigned BITS      = 4,
  parameter int unsigned BASE_T    = 8,
  parameter int unsigned AW        = $clog2(ROWS_HALF),
  parameter int unsigned CW        = $clog2(COLS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  hub75_bcm_scanner_if.master bus,
  output logic                r0,
  output logic                g0,
  output logic                b0,
  output logic                r1,
  output logic                g1,
  output logic                b1,
  output logic [AW-1:0]       addr,
  output logic                clk_out,
  output logic                latch,
  output logic                oe,
  output logic                frame_done
);
  localparam int unsigned PW   = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int unsigned DMAX = BASE_T << (BITS - 1);
  localparam int unsigned DW   = $clog2(DMAX + 1);
  localparam int unsigned SCW  = CW + 1;

  typedef enum logic [2:0] {StIdle, StPrefetch, StShift, StBlank, StLatch, StDisplay} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   row_q, row_d, addr_q, addr_d;
  logic [PW-1:0]   plane_q, plane_d;
  logic [SCW-1:0]  sc_q, sc_d;
  logic [DW-1:0]   dc_q, dc_d;
  logic            buf_q, buf_d, fd_q, fd_d, ack_q, ack_d;
  logic [5:0]      colour_q, colour_d, plane_bits, colour;
  logic [CW-1:0]   col, col_addr;
  logic [BITS-1:0] fld;
  logic            phase_b;

  assign col     = sc_q[CW:1];
  assign phase_b = sc_q[0];

  // plane_bits[5] is r0, plane_bits[0] is b1.
  always_comb begin
    fld        = '0;
    plane_bits = '0;
    for (int k = 0; k < 6; k++) begin
      fld           = bus.rd_data[k*BITS +: BITS];
      plane_bits[k] = fld[plane_q];
    end
  end

  // Phase B prefetches the next column so its data lands in the following phase A.
  always_comb begin
    col_addr = '0;
    if (state_q == StShift) begin
      col_addr = (phase_b && col != CW'(COLS - 1)) ? col + CW'(1) : col;
    end
  end

  assign bus.rd_addr  = {buf_q, row_q, col_addr};
  assign bus.swap_ack = ack_q;
  assign bus.buf_sel  = buf_q;

  // Colour follows memory only in phase A and is held from the register otherwise.
  assign colour = (state_q == StShift && !phase_b) ? plane_bits : colour_q;
  assign {r0, g0, b0, r1, g1, b1} = colour;

  assign clk_out    = (state_q == StShift) && phase_b;
  assign latch      = (state_q == StLatch);
  assign oe         = (state_q != StDisplay);
  assign addr       = addr_q;
  assign frame_done = fd_q;

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    plane_d  = plane_q;
    sc_d     = sc_q;
    dc_d     = dc_q;
    addr_d   = addr_q;
    buf_d    = buf_q;
    colour_d = colour_q;
    fd_d     = 1'b0;
    ack_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en) state_d = StPrefetch;
      end
      StPrefetch: begin
        sc_d    = '0;
        state_d = StShift;
      end
      StShift: begin
        if (!phase_b) colour_d = plane_bits;
        sc_d = sc_q + SCW'(1);
        if (sc_q == SCW'(2 * COLS - 1)) state_d = StBlank;
      end
      StBlank: begin
        addr_d  = row_q;
        state_d = StLatch;
      end
      StLatch: begin
        dc_d    = '0;
        state_d = StDisplay;
      end
      StDisplay: begin
        dc_d = dc_q + DW'(1);
        if (dc_q == DW'((BASE_T << plane_q) - 1)) begin
          state_d = StPrefetch;
          if (plane_q != PW'(BITS - 1)) begin
            plane_d = plane_q + PW'(1);
          end else begin
            plane_d = '0;
            row_d   = row_q + AW'(1);
            if (row_q == AW'(ROWS_HALF - 1)) begin
              fd_d = 1'b1;
              if (bus.swap_req) begin
                buf_d = ~buf_q;
                ack_d = 1'b1;
              end
              if (!en) state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      row_q    <= '0;
      plane_q  <= '0;
      sc_q     <= '0;
      dc_q     <= '0;
      addr_q   <= '0;
      buf_q    <= 1'b0;
      colour_q <= '0;
      fd_q     <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      plane_q  <= plane_d;
      sc_q     <= sc_d;
      dc_q     <= dc_d;
      addr_q   <= addr_d;
      buf_q    <= buf_d;
      colour_q <= colour_d;
      fd_q     <= fd_d;
      ack_q    <= ack_d;
    end
  end
endmodule

// File: tb/tb_hub75_bcm_scanner.sv
// Bench for hub75_bcm_scanner: a frame-position model derived from plane/row cycle arithmetic
// predicts every panel output each cycle while randomized memory and swap timing are applied.
module tb_hub75_bcm_scanner;
  localparam int unsigned COLS      = 4;
  localparam int unsigned ROWS_HALF = 2;
  localparam int unsigned BITS      = 2;
  localparam int unsigned BASE_T    = 2;
  localparam int unsigned AW        = $clog2(ROWS_HALF);
  localparam int unsigned CW        = $clog2(COLS);
  localparam int unsigned DEPTH     = 2 ** (1 + AW + CW);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic r0, g0, b0, r1, g1, b1;
  logic [AW-1:0] addr;
  logic clk_out, latch, oe, frame_done;
  logic [6*BITS-1:0] mem [DEPTH];

  hub75_bcm_scanner_if #(.AW(AW), .CW(CW), .BITS(BITS)) bus ();

  hub75_bcm_scanner #(
    .COLS(COLS), .ROWS_HALF(ROWS_HALF), .BITS(BITS), .BASE_T(BASE_T), .AW(AW), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .bus(bus),
    .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
    .addr(addr), .clk_out(clk_out), .latch(latch), .oe(oe), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) bus.rd_data <= mem[bus.rd_addr];

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: scanning flag, cycle index within the frame, and registered outputs.
  logic       m_run = 1'b0;
  int         m_t   = 0;
  logic       m_buf = 1'b0;
  int         m_addr = 0;
  logic [5:0] m_col = '0;
  logic       m_fd  = 1'b0;
  logic       m_ack = 1'b0;

  int   oe_low_p [BITS];
  int   rises;
  int   latch_cnt;
  logic prev_clk = 1'b0;
  int   fd_cyc[$];
  int   ack_cyc[$];
  logic rise_r0 [BITS][COLS];

  function automatic int plane_len(input int p);
    return 2 * COLS + 3 + (BASE_T << p);
  endfunction

  function automatic int row_len();
    int s;
    s = 0;
    for (int p = 0; p < BITS; p++) s += plane_len(p);
    return s;
  endfunction

  function automatic int frame_len();
    return ROWS_HALF * row_len();
  endfunction

  function automatic logic [5:0] pix(input int b, input int row, input int c, input int p);
    logic [6*BITS-1:0] w;
    logic [5:0] v;
    w = mem[(b << (AW + CW)) | (row << CW) | c];
    for (int k = 0; k < 6; k++) v[k] = w[k*BITS+p];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic clr_stats();
    for (int p = 0; p < BITS; p++) begin
      oe_low_p[p] = 0;
      for (int c = 0; c < COLS; c++) rise_r0[p][c] = 1'bx;
    end
    rises     = 0;
    latch_cnt = 0;
    fd_cyc.delete();
    ack_cyc.delete();
  endtask

  // Check the current cycle against the model, then advance both by one clock.
  task automatic tick();
    int row, plane, po, s, c, r, e_rd;
    logic e_oe, e_latch, e_clk, chk_rd, in_b;
    row = 0; plane = 0; po = 0; s = 0; c = 0; e_rd = 0;
    e_oe = 1'b1; e_latch = 1'b0; e_clk = 1'b0; chk_rd = 1'b0; in_b = 1'b0;
    if (m_run) begin
      row = m_t / row_len();
      r   = m_t % row_len();
      while (r >= plane_len(plane)) begin
        r -= plane_len(plane);
        plane++;
      end
      po = r;
      if (po == 0) begin
        chk_rd = 1'b1;
        e_rd   = (int'(m_buf) << (AW + CW)) | (row << CW);
      end else if (po <= 2 * COLS) begin
        s = po - 1;
        c = s / 2;
        if (s % 2 == 0) begin
          m_col = pix(int'(m_buf), row, c, plane);
        end else begin
          e_clk = 1'b1;
          in_b  = 1'b1;
          if (c < COLS - 1) begin
            chk_rd = 1'b1;
            e_rd   = (int'(m_buf) << (AW + CW)) | (row << CW) | (c + 1);
          end
        end
      end else if (po == 2 * COLS + 2) begin
        e_latch = 1'b1;
        m_addr  = row;
      end else if (po > 2 * COLS + 2) begin
        e_oe = 1'b0;
      end
    end
    chk("oe", 32'(oe), 32'(e_oe));
    chk("latch", 32'(latch), 32'(e_latch));
    chk("clk_out", 32'(clk_out), 32'(e_clk));
    chk("addr", 32'(addr), 32'(m_addr));
    chk("buf_sel", 32'(bus.buf_sel), 32'(m_buf));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
    chk("swap_ack", 32'(bus.swap_ack), 32'(m_ack));
    chk("rgb", 32'({r0, g0, b0, r1, g1, b1}), 32'(m_col));
    if (chk_rd) chk("rd_addr", 32'(bus.rd_addr), e_rd);

    if (m_run && oe === 1'b0) oe_low_p[plane]++;
    if (clk_out === 1'b1 && prev_clk === 1'b0) begin
      rises++;
      if (in_b && row == 0 && m_buf == 1'b0) rise_r0[plane][c] = r0;
    end
    prev_clk = clk_out;
    if (latch === 1'b1) latch_cnt++;
    if (frame_done === 1'b1) fd_cyc.push_back(cyc);
    if (bus.swap_ack === 1'b1) ack_cyc.push_back(cyc);

    if (!rst) begin
      m_run = 1'b0; m_t = 0; m_buf = 1'b0; m_addr = 0; m_col = '0; m_fd = 1'b0; m_ack = 1'b0;
    end else begin
      m_fd  = 1'b0;
      m_ack = 1'b0;
      if (!m_run) begin
        if (en) begin
          m_run = 1'b1;
          m_t   = 0;
        end
      end else if (m_t == frame_len() - 1) begin
        m_fd = 1'b1;
        if (bus.swap_req) begin
          m_buf = ~m_buf;
          m_ack = 1'b1;
        end
        m_t = 0;
        if (!en) m_run = 1'b0;
      end else begin
        m_t++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int tgt);
    int k;
    k = 0;
    while (!(m_run && m_t == tgt) && k < 4 * frame_len()) begin
      tick();
      k++;
    end
    chk("run_to_reached", 32'(k < 4 * frame_len()), 32'd1);
  endtask

  task automatic wait_ack();
    int k;
    k = 0;
    while (!m_ack && k < 2 * frame_len()) begin
      tick();
      k++;
    end
    chk("ack_within_budget", 32'(bus.swap_ack), 32'd1);
    bus.swap_req = 1'b0;
  endtask

  initial begin
    logic [6*BITS-1:0] w;
    int tgt;
    bus.swap_req = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '1;
    clr_stats();
    en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    repeat (3) tick();
    chk("rst_oe", 32'(oe), 32'd1);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_buf_sel", 32'(bus.buf_sel), 32'd0);
    chk("rst_latch", 32'(latch), 32'd0);
    chk("rst_clk_out", 32'(clk_out), 32'd0);

    // All-ones memory: BCM on-times, shift edges and frame period.
    rst = 1'b1;
    tick();
    chk("prefetch_rd_addr", 32'(bus.rd_addr), 32'd0);
    clr_stats();
    repeat (frame_len()) tick();
    for (int p = 0; p < BITS; p++) chk("oe_low_plane", 32'(oe_low_p[p]), ROWS_HALF * (BASE_T << p));
    chk("clk_out_rises", 32'(rises), ROWS_HALF * BITS * COLS);
    repeat (frame_len() + 1) tick();
    chk("fd_count", 32'(fd_cyc.size()), 32'd2);
    chk("fd_period", (fd_cyc.size() >= 2) ? 32'(fd_cyc[1] - fd_cyc[0]) : 32'hffff_ffff, 32'd56);

    // Reset mid-scan, then load random data with a single marked pixel in buffer 0 row 0.
    rst = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < DEPTH; i++) mem[i] = (6 * BITS)'($urandom);
    for (int c = 0; c < COLS; c++) begin
      w = mem[c];
      w[5*BITS+1] = (c == 2);
      w[5*BITS]   = 1'b0;
      mem[c] = w;
    end
    rst = 1'b1;
    tick();
    clr_stats();
    repeat (frame_len()) tick();
    for (int p = 0; p < BITS; p++) begin
      for (int c = 0; c < COLS; c++) chk("r0_order", 32'(rise_r0[p][c]), 32'(p == 1 && c == 2));
    end

    // Mid-frame request waits for the wrap.
    run_to(10);
    bus.swap_req = 1'b1;
    clr_stats();
    wait_ack();
    chk("swap_buf_sel", 32'(bus.buf_sel), 32'd1);
    chk("swap_rd_msb", 32'(bus.rd_addr[AW+CW]), 32'd1);
    chk("swap_with_fd", 32'({bus.swap_ack, frame_done}), 32'd3);
    tick();
    chk("ack_once", 32'(ack_cyc.size()), 32'd1);

    // Request raised on the wrap cycle itself.
    run_to(frame_len() - 1);
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    chk("wrap_req_ack", 32'(bus.swap_ack), 32'd1);
    chk("wrap_req_buf", 32'(bus.buf_sel), 32'd0);

    repeat (3) begin
      tgt = int'($urandom_range(0, frame_len() - 1));
      run_to(tgt);
      bus.swap_req = 1'b1;
      wait_ack();
    end

    // Enable drop in the last row: frame completes, then idles.
    run_to(row_len() + 5);
    en = 1'b0;
    while (m_run && cyc < 20000) tick();
    chk("idle_oe", 32'(oe), 32'd1);
    chk("idle_fd", 32'(frame_done), 32'd1);
    repeat (5) tick();
    en = 1'b1;
    repeat (frame_len()) tick();

    // Reset during a DISPLAY of row 1.
    run_to(row_len() + plane_len(0) + 2 * COLS + 4);
    chk("pre_rst_display", 32'(oe), 32'd0);
    clr_stats();
    rst = 1'b0;
    tick();
    chk("rst_disp_oe", 32'(oe), 32'd1);
    chk("rst_disp_addr", 32'(addr), 32'd0);
    chk("rst_disp_latch", 32'(latch_cnt), 32'd0);
    rst = 1'b1;
    repeat (frame_len()) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/hub75_bcm_scanner.md
Name: hub75_bcm_scanner

Overview:
- Parametrised HUB75 panel scan engine; successor to the fixed single-bit panel driver under top.
- Reads pixel pairs (upper and lower half-panel) from an external double-buffered frame memory.
- Drives r0/g0/b0/r1/g1/b1, addr, clk_out, latch and oe with binary-code-modulated (BCM) colour depth.
- Adds a frame-swap handshake so an image changer can flip buffers tear-free at frame boundaries.

Parameters:
- COLS, 64, panel columns shifted per row; power of 2, minimum 2.
- ROWS_HALF, 32, scan rows (half panel height); power of 2, minimum 2.
- BITS, 4, colour bits per channel (BCM planes); range 1..8.
- BASE_T, 8, display cycles for plane 0; plane p displays BASE_T<<p cycles.
- AW, $clog2(ROWS_HALF), addr width.
- CW, $clog2(COLS), column index width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- en  in  1  scan enable; sampled only in IDLE and at each row wrap.
- swap_req  in  1  level request to flip the display buffer; hold until swap_ack.
- swap_ack  out  1  one-cycle pulse when the flip is taken.
- buf_sel  out  1  buffer currently displayed.
- rd_addr  out  1+AW+CW  memory read address {buf_sel,row,col}.
- rd_data  in  6*BITS  {r0,g0,b0,r1,g1,b1}, each BITS wide, MSB first; valid the cycle after rd_addr.
- r0,g0,b0,r1,g1,b1  out  1 each  colour bit of the current plane.
- addr  out  AW  row select.
- clk_out  out  1  panel shift clock.
- latch  out  1  panel latch strobe.
- oe  out  1  panel output enable, active-low.
- frame_done  out  1  one-cycle pulse after the last plane of row ROWS_HALF-1.

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE; row=0, plane=0, col=0; buf_sel=0; oe=1; all other outputs 0. Reset mid-scan aborts immediately with no partial latch.
- IDLE: oe=1. If en=1, go to PREFETCH.
- PREFETCH (1 cycle): rd_addr={buf_sel,row,0}.
- SHIFT (2*COLS cycles), column c:
  - Phase A: clk_out=0; colour outputs = bit[plane] of the rd_data fetched for c.
  - Phase B: clk_out=1; colour outputs held; rd_addr advances to c+1 (not issued after c=COLS-1).
  - Colour outputs change only when clk_out=0.
- BLANK (1 cycle): oe=1, clk_out=0.
- LATCH (1 cycle): latch=1; addr updates to row on entry to this state.
- DISPLAY (BASE_T<<plane cycles): oe=0, latch=0.
- After DISPLAY:
  - plane<BITS-1: plane+1, go to PREFETCH.
  - Otherwise plane=0 and row+1.
- Row wrap (row=ROWS_HALF-1 to 0):
  - frame_done=1 for one cycle.
  - If swap_req=1, buf_sel toggles and swap_ack=1 in that same cycle.
  - If en=0, go to IDLE; otherwise go to PREFETCH.
- swap_req asserted mid-frame waits for the next wrap. A request arriving on the wrap cycle itself is taken.
- oe is 0 only in DISPLAY. addr and latch never change while oe=0.
- Cycles per plane = 1+2*COLS+1+1+(BASE_T<<plane).
- Counters wrap with no overflow states. The rd_addr col field is CW bits.

Test Plan:
- Reset values: COLS=4, ROWS_HALF=2, BITS=2, BASE_T=2; hold rst=0 for 5 cycles, en=1 -> oe=1, addr=0, buf_sel=0, latch=0, clk_out=0; PREFETCH starts the cycle after rst=1.
- BCM timing: same config, memory returns all ones -> plane0 oe low for 2 cycles, plane1 for 4; 4 clk_out rising edges per plane; frame_done period 56 cycles.
- Data ordering: buffer0 row0 col c = r0 bit1 set only for c=2 -> plane1 shift shows r0=1 only at the 3rd clk_out rise; plane0 shows r0=0 throughout.
- Swap handshake: raise swap_req at cycle 10 of frame -> swap_ack and buf_sel=1 coincide with frame_done; subsequent rd_addr MSB=1; no ack mid-frame.
- Enable drop: en=0 mid-row1 -> row completes, frame_done pulses, then IDLE with oe=1.
- Reset mid-DISPLAY: rst=0 -> next cycle oe=1, addr=0, state IDLE, no latch pulse.
